// File: rtl/pipelined_csel_adder.sv
// -----------------------------------------------------------------------------
// pipelined_csel_adder
//
// Pipelined carry-select adder/subtractor. The operands are cut into BLK-bit
// blocks and block k is resolved in pipeline stage k. Each stage forms the
// block sum for carry-in 0 and carry-in 1 in parallel. The carry registered by
// the previous stage then picks one of the two. A valid/ready handshake on both
// ends gives full backpressure and one operation per cycle.
//
// Parameters
//   WIDTH : operand/result width, a multiple of BLK (WIDTH >= BLK)
//   BLK   : carry-select block width; NSTG = WIDTH/BLK stages (= latency)
//
// Ports
//   clk       : clock, all logic on the rising edge
//   rst       : synchronous active-high reset, flushes every stage
//   in_valid  : operand set valid
//   in_ready  : block accepts an operand set this cycle
//   a, b      : operands
//   cin       : carry-in (add) / borrow-in (sub)
//   sub       : 0 = a + b + cin, 1 = a - b - cin
//   out_valid : result valid
//   out_ready : downstream accepts the result
//   sum       : result
//   cout      : raw carry out of the MSB block (sub: 1 = no borrow)
//   ovf       : two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / BLK;

    // Stage registers. a_reg/b_reg carry the operand (b already conditioned
    // for subtraction) down the pipe. Later stages read the upper slices, and
    // the last stage reads the MSBs for the overflow flag.
    logic [NSTG-1:0]  valid_reg;
    logic [NSTG-1:0]  carry_reg;
    logic [WIDTH-1:0] a_reg   [NSTG];
    logic [WIDTH-1:0] b_reg   [NSTG];
    logic [WIDTH-1:0] sum_reg [NSTG];

    // Per-stage inputs and next-state values.
    logic [NSTG-1:0]  vin;
    logic [NSTG-1:0]  cin_in;
    logic [WIDTH-1:0] a_in     [NSTG];
    logic [WIDTH-1:0] b_in     [NSTG];
    logic [WIDTH-1:0] sum_in   [NSTG];
    logic [WIDTH-1:0] sum_next [NSTG];
    logic [NSTG-1:0]  carry_next;

    // Advance chain: a stage may load when it is empty or when its content
    // moves on. This is evaluated from the output end backwards. in_ready
    // therefore depends combinationally on out_ready, but never on in_valid.
    logic [NSTG-1:0]  adv;

    always_comb begin
        adv = '0;
        adv[NSTG-1] = !valid_reg[NSTG-1] || out_ready;
        for (int k = NSTG - 2; k >= 0; k--) begin
            adv[k] = !valid_reg[k] || adv[k+1];
        end
    end

    generate
        for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
            localparam logic [WIDTH-1:0] BLK_MASK = WIDTH'({BLK{1'b1}}) << (gi * BLK);

            logic [BLK-1:0] a_sl;
            logic [BLK-1:0] b_sl;
            logic [BLK:0]   blk_c0;
            logic [BLK:0]   blk_c1;
            logic [BLK:0]   blk_sel;

            if (gi == 0) begin : g_head
                // Subtraction is a + ~b + ~cin, which equals a - b - cin
                // modulo 2^WIDTH.
                assign vin[0]    = in_valid;
                assign a_in[0]   = a;
                assign b_in[0]   = sub ? ~b : b;
                assign cin_in[0] = sub ^ cin;
                assign sum_in[0] = '0;
            end else begin : g_link
                assign vin[gi]    = valid_reg[gi-1];
                assign a_in[gi]   = a_reg[gi-1];
                assign b_in[gi]   = b_reg[gi-1];
                assign cin_in[gi] = carry_reg[gi-1];
                assign sum_in[gi] = sum_reg[gi-1];
            end

            assign a_sl = a_in[gi][gi*BLK +: BLK];
            assign b_sl = b_in[gi][gi*BLK +: BLK];

            // Both candidate block sums are computed up front. The incoming
            // carry only drives the final select.
            assign blk_c0  = {1'b0, a_sl} + {1'b0, b_sl};
            assign blk_c1  = {1'b0, a_sl} + {1'b0, b_sl} + {{BLK{1'b0}}, 1'b1};
            assign blk_sel = cin_in[gi] ? blk_c1 : blk_c0;

            assign sum_next[gi]   = (sum_in[gi] & ~BLK_MASK)
                                  | (WIDTH'(blk_sel[BLK-1:0]) << (gi * BLK));
            assign carry_next[gi] = blk_sel[BLK];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            carry_reg <= '0;
            for (int k = 0; k < NSTG; k++) begin
                a_reg[k]   <= '0;
                b_reg[k]   <= '0;
                sum_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (adv[k]) begin
                    valid_reg[k] <= vin[k];
                    // Data only moves with a real operation. When a stage
                    // drains without an incoming operation, it keeps its last
                    // contents.
                    if (vin[k]) begin
                        a_reg[k]     <= a_in[k];
                        b_reg[k]     <= b_in[k];
                        sum_reg[k]   <= sum_next[k];
                        carry_reg[k] <= carry_next[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_reg[NSTG-1];
    assign sum       = sum_reg[NSTG-1];
    assign cout      = carry_reg[NSTG-1];

    // Signed overflow: the operands have the same sign and the result sign
    // differs from it. For subtraction the conditioned b is used.
    assign ovf = (a_reg[NSTG-1][WIDTH-1] == b_reg[NSTG-1][WIDTH-1])
              && (sum_reg[NSTG-1][WIDTH-1] != a_reg[NSTG-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_csel_adder
//
// The bench keeps a reference queue of expected results. Each entry is
// computed with plain integer arithmetic when its operation is accepted. A
// compare process runs on every falling edge. It checks in_ready, out_valid,
// the result fields and output stability under stall against that queue.
// Directed sequences pin the model with hand-computed literals. Randomized
// traffic then exercises the handshake.
// -----------------------------------------------------------------------------
module tb_pipelined_csel_adder;

    localparam int W = 16;
    localparam int B = 4;
    localparam int N = W / B;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_csel_adder #(.WIDTH(W), .BLK(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int n_tx   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           t;
    } exp_t;

    exp_t q[$];

    // Reference result from the arithmetic definition.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tcin, input logic tsub, input int t);
        exp_t r;
        logic [W-1:0] bp;
        logic [W:0]   full;
        bp   = tsub ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, bp} + (W+1)'(tsub ? !tcin : tcin);
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.o  = (ta[W-1] == bp[W-1]) && (full[W-1] != ta[W-1]);
        r.t  = t;
        return r;
    endfunction

    // Compare process. An accept or emit seen at the falling edge of cycle c
    // takes effect at the following rising edge. The oldest operation is
    // never blocked by anything ahead of it, so it is visible exactly N
    // cycles after its accept.
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_vec;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            logic exp_ov;
            check("in_ready", in_ready, out_ready || (q.size() < N));
            exp_ov = 1'b0;
            if (q.size() > 0) exp_ov = (cyc - q[0].t) >= N;
            check("out_valid", out_valid, exp_ov);
            if (prev_stall) check("stall_hold", {out_valid, sum, cout, ovf}, {1'b1, prev_vec});
            if (out_valid && q.size() > 0) begin
                check("sum", sum, q[0].s);
                check("cout", cout, q[0].c);
                check("ovf", ovf, q[0].o);
                if (out_ready) begin
                    $display("tx %0d: cycle %0d sum=0x%04h cout=%0b ovf=%0b", n_tx, cyc, sum, cout, ovf);
                    n_tx++;
                    void'(q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_vec   = {sum, cout, ovf};
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, cyc));
        end
    end

    // Single operation with out_ready held high. The task checks the exact
    // latency and the literal result.
    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int  t0;
        bit  got;
        @(posedge clk); #1;
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        t0 = cyc;
        check({nm, "_accept"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                check({nm, "_latency"}, cyc - t0, N);
                check({nm, "_sum"}, sum, es);
                check({nm, "_cout"}, cout, ec);
                check({nm, "_ovf"}, ovf, eo);
            end
        end
        if (!got) check({nm, "_timeout"}, 1'b0, 1'b1);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] outs[$];
        int  sent;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Directed literal cases.
        run_op("add1",    16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        run_op("ripple",  16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("full_c1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("full_c0", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        run_op("povf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_b0",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_b1",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);

        // Backpressure: 8 ops streamed in, with the output stalled in
        // relative cycles 5-7.
        sent = 0;
        for (int j = 0; j < 40 && outs.size() < 8; j++) begin
            @(posedge clk); #1;
            in_valid  = (sent < 8);
            a = W'(sent); b = 16'h0100; cin = 1'b0; sub = 1'b0;
            out_ready = !(j >= 5 && j <= 7);
            @(negedge clk);
            if (j == 5) check("bp_in_ready_full", in_ready, 1'b0);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) outs.push_back(sum);
        end
        #1 in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", outs.size(), 8);
        for (int i = 0; i < outs.size(); i++) check("bp_order", outs[i], 16'h0100 + W'(i));

        // Reset with three operations in flight and out_ready high.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = W'(i + 1); b = 16'h0010; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_sum", sum, 16'h0000);
        check("mrst_cout", cout, 1'b0);
        check("mrst_ovf", ovf, 1'b0);
        check("mrst_in_ready", in_ready, 1'b1);
        repeat (6) @(negedge clk);
        run_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Randomized traffic under random backpressure.
        for (int j = 0; j < 400; j++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a   = rand_opnd();
            b   = rand_opnd();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
        end

        // Drain, bounded.
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 30 && q.size() > 0; j++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
